// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch program counter. It chooses the next PC from
// the sequential step, an EX-stage redirect, a stall hold or a halt freeze.
// After a redirect it raises squash cycles, and it manages the HALTED state
// and restart.
//
// Handshake: there is no valid/ready pair on this block. Every request input
// is a level that is sampled at the rising clock edge. Every output is
// registered, so a request sampled at edge N is visible on the outputs
// just after edge N. fetch_valid_o qualifies pc_o for the fetch stage in
// the same cycle.
module pc_sequencer #(
  parameter int unsigned PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [31:0]     br_target_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            halted_o,
  output logic            err_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e    state;
  logic [2:0] flush_cnt;

  // Only the low PC_W bits of the target address the instruction memory.
  logic unused_target_bits;
  assign unused_target_bits = ^br_target_i[31:PC_W];

  logic [PC_W-1:0] pc_next_seq;
  logic            target_misaligned;
  assign pc_next_seq       = pc_o + PC_W'(4);
  assign target_misaligned = (br_target_i[1:0] != 2'b00);

  // Expose the FSM state so that checkers can observe it.
  assign state_o = state;

  // Sequencer FSM: updates the PC, state, flush counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_RUN;
      pc_o          <= RESET_PC;
      flush_cnt     <= 3'd0;
      fetch_valid_o <= 1'b1;
      flush_o       <= 1'b0;
      halted_o      <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_i) begin
            // Halt: freeze the PC. One squash pulse clears the younger stages.
            state         <= ST_HALTED;
            flush_o       <= 1'b1;
            halted_o      <= 1'b1;
            fetch_valid_o <= 1'b0;
          end else if (br_taken_i && target_misaligned) begin
            // A misaligned redirect is fatal. Drop the target and halt with an error.
            state         <= ST_HALTED;
            flush_o       <= 1'b1;
            halted_o      <= 1'b1;
            fetch_valid_o <= 1'b0;
            err_o         <= 1'b1;
          end else if (br_taken_i) begin
            state         <= ST_FLUSH;
            pc_o          <= br_target_i[PC_W-1:0];
            flush_cnt     <= 3'(FLUSH_CYC);
            flush_o       <= 1'b1;
            fetch_valid_o <= 1'b1;
          end else if (stall_i) begin
            flush_o       <= 1'b0;
          end else begin
            pc_o          <= pc_next_seq;
            flush_o       <= 1'b0;
          end
        end

        ST_FLUSH: begin
          // Requests seen here come from squashed instructions and are ignored.
          pc_o          <= pc_next_seq;
          fetch_valid_o <= 1'b1;
          if (flush_cnt <= 3'd1) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
            flush_o   <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
            flush_o   <= 1'b1;
          end
        end

        ST_HALTED: begin
          flush_o <= 1'b0;
          if (resume_i) begin
            state         <= ST_RUN;
            pc_o          <= RESET_PC;
            halted_o      <= 1'b0;
            err_o         <= 1'b0;
            fetch_valid_o <= 1'b1;
          end
        end

        default: begin
          state         <= ST_RUN;
          pc_o          <= RESET_PC;
          flush_cnt     <= 3'd0;
          fetch_valid_o <= 1'b1;
          flush_o       <= 1'b0;
          halted_o      <= 1'b0;
          err_o         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and decides its next value each cycle: sequential PC+4, a taken-branch/jump target from the execute-stage branch logic, a hold on a hazard stall, or a freeze on halt.
- Issues squash (flush) cycles for wrong-path instructions after a redirect.
- Manages the HALTED state and restart.
- Sits between the EX-stage branch resolution and the instruction-fetch stage.

Parameters:
PC_W, 9, width of the PC register (byte address; instruction memory is 2^PC_W bytes)
RESET_PC, 0, PC value after reset and after resume
FLUSH_CYC, 2, number of squash cycles after a taken redirect (IF/ID + ID/EX); legal range 1..7

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
stall_i  input  1  load-use hazard: hold PC this cycle
br_taken_i  input  1  EX-stage branch/jump taken (redirect request)
br_target_i  input  32  redirect target byte address
halt_i  input  1  EX-stage halt instruction
resume_i  input  1  restart request, honoured only in HALTED
pc_o  output  PC_W  current fetch PC (registered)
fetch_valid_o  output  1  fetch at pc_o is on the correct path and may be issued
flush_o  output  1  squash IF/ID and ID/EX contents this cycle
halted_o  output  1  core halted
err_o  output  1  sticky misaligned-target error, cleared by resume or reset

Behaviour:
- All outputs are registered.
- Values while reset is low at a clock edge:
  - pc_o = RESET_PC
  - state = RUN
  - fetch_valid_o = 1, flush_o = 0, halted_o = 0, err_o = 0
  - flush counter = 0
- States: RUN, FLUSH, HALTED.
- RUN: inputs are evaluated in strict priority order.
  1. halt_i=1: pc holds; next state HALTED; flush_o=1 for exactly one cycle; halted_o=1; fetch_valid_o=0.
  2. br_taken_i=1 and br_target_i[1:0]!=0: treated as halt with err_o=1. The target is discarded and pc holds.
  3. br_taken_i=1 and target aligned: pc <= br_target_i[PC_W-1:0] (upper bits ignored); next state FLUSH; counter loaded with FLUSH_CYC; flush_o=1 from the next cycle.
  4. stall_i=1: pc holds; flush_o=0.
  5. Otherwise: pc <= pc + 4, modulo 2^PC_W; (2^PC_W)-4 wraps to 0.
- FLUSH:
  - flush_o=1 every cycle in this state.
  - pc advances by 4 each cycle (target-path fetches are valid, fetch_valid_o=1).
  - Counter decrements each cycle; on reaching 1 the state returns to RUN, so flush_o is high for exactly FLUSH_CYC cycles.
  - br_taken_i, halt_i and stall_i are ignored: they come from squashed instructions.
- HALTED:
  - pc holds; fetch_valid_o=0; flush_o=0 after its entry pulse; halted_o=1.
  - halt_i and br_taken_i are ignored.
  - resume_i=1: pc <= RESET_PC; next state RUN; halted_o=0; err_o=0; fetch_valid_o=1 from the next cycle.
- Redirect latency: target appears on pc_o one cycle after br_taken_i is sampled.
- Simultaneous events:
  - halt beats branch; branch beats stall.
  - resume_i is ignored outside HALTED.
  - If resume_i and reset are active in the same cycle, reset wins; the result is the same state anyway.
- Reset asserted mid-FLUSH or mid-HALTED: immediate return to reset values on that edge; no residual flush pulses.

Test Plan:
1. Reset low 2 cycles, then release with no requests → pc_o steps 0,4,8,12 on consecutive cycles; flush_o=0; fetch_valid_o=1.
2. At pc_o=0x010, assert br_taken_i with br_target_i=0x0000_0040 for 1 cycle → next pc_o=0x040, then 0x044, 0x048; flush_o=1 for exactly 2 cycles. A br_taken_i pulse during those cycles has no effect.
3. At pc_o=0x020, assert stall_i for 3 cycles → pc_o stays 0x020 for 3 cycles, then 0x024; flush_o stays 0.
4. Assert halt_i and br_taken_i (target 0x80) together at pc_o=0x030 → pc_o stays 0x030; halted_o=1; fetch_valid_o=0; flush_o is a 1-cycle pulse. Pulsing resume_i then gives pc_o=0x000 and halted_o=0 on the next cycle.
5. Branch with br_target_i=0x0000_0042 → HALTED, err_o=1, pc unchanged. resume_i clears err_o. Also: pc_o=0x1FC with no requests → wraps to 0x000.
6. Enter FLUSH, then assert reset low for 1 cycle in the first flush cycle → pc_o=0, flush_o=0 immediately after that edge, state RUN.
